dmem_lane_ctrl: RTL



---
 rtl/dmem_pkg.sv | 47 ++++
 rtl/dmem_lane_map.sv | 40 ++++
 rtl/dmem_lane_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store front end: funct3 codes,
// FSM state encoding and the access-size decoder.
package dmem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic       zext;
    logic [2:0] nbytes;
  } size_t;

  // nbytes is forced to 0 for illegal requests so no lane is ever mapped.
  function automatic size_t size_decode(input logic [2:0] funct3, input logic we);
    size_t r;
    r.illegal = 1'b0;
    r.zext    = (funct3 == F3_BU) || (funct3 == F3_HU);
    r.nbytes  = 3'd0;
    case (funct3[1:0])
      F3_B[1:0]: r.nbytes = 3'd1;
      F3_H[1:0]: r.nbytes = 3'd2;
      F3_W[1:0]: r.nbytes = 3'd4;
      default:   r.illegal = 1'b1;
    endcase
    if (we && funct3[2]) begin
      r.illegal = 1'b1;
    end
    if (r.illegal) begin
      r.nbytes = 3'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_map.sv
// Combinational byte-lane mapping: per-lane mask, word address and write byte,
// plus the read rotation that brings lane data back into byte order.
module dmem_lane_map
  import dmem_pkg::*;
#(
  parameter int WA = 8
) (
  input  logic [1:0]              off,
  input  logic [WA-1:0]           word,
  input  logic [2:0]              size,
  input  logic [31:0]             wdata,
  input  logic [31:0]             dout,
  output logic [NUM_LANES-1:0]    mask,
  output logic [NUM_LANES*WA-1:0] lane_addr,
  output logic [31:0]             din,
  output logic [31:0]             rbytes
);

  logic [WA-1:0] word_inc;
  assign word_inc = word + WA'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [1:0] k;
      logic [1:0] src;

      // k: which request byte lands on this lane; src: which lane feeds byte gi.
      assign k   = LANE - off;
      assign src = LANE + off;

      assign mask[gi]                 = ({1'b0, k} < size);
      assign lane_addr[gi*WA +: WA]   = (LANE >= off) ? word : word_inc;
      assign din[8*gi +: 8]           = wdata[{k, 3'b000} +: 8];
      assign rbytes[8*gi +: 8]        = dout[{src, 3'b000} +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Load/store front end for four byte-lane brams: one outstanding request,
// unaligned accesses served in a single lane cycle, extended load results.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_WE,
  input  logic [2:0]                  REQ_FUNCT3,
  input  logic [ADDR_WIDTH-1:0]       REQ_ADDR,
  input  logic [31:0]                 REQ_WDATA,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [31:0]                 RSP_RDATA,
  output logic                        RSP_ERR,
  output logic [4*(ADDR_WIDTH-2)-1:0] LANE_W_ADDR,
  output logic [4*(ADDR_WIDTH-2)-1:0] LANE_R_ADDR,
  output logic [3:0]                  LANE_WE,
  output logic [3:0]                  LANE_RE,
  output logic [31:0]                 LANE_DIN,
  input  logic [31:0]                 LANE_DOUT
);

  localparam int WA = ADDR_WIDTH - 2;

  state_t                  state_reg, state_next;
  logic                    we_reg;
  logic [2:0]              funct3_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             wdata_reg;
  logic [31:0]             rdata_reg;
  logic                    err_reg;

  size_t                   dec;
  logic [NUM_LANES-1:0]    mask;
  logic [NUM_LANES*WA-1:0] lane_addr;
  logic [31:0]             rbytes;
  logic [31:0]             load_ext;

  assign dec = size_decode(funct3_reg, we_reg);

  dmem_lane_map #(
    .WA(WA)
  ) u_map (
    .off       (addr_reg[1:0]),
    .word      (addr_reg[ADDR_WIDTH-1:2]),
    .size      (dec.nbytes),
    .wdata     (wdata_reg),
    .dout      (LANE_DOUT),
    .mask      (mask),
    .lane_addr (lane_addr),
    .din       (LANE_DIN),
    .rbytes    (rbytes)
  );

  assign LANE_W_ADDR = lane_addr;
  assign LANE_R_ADDR = lane_addr;
  assign RSP_RDATA   = rdata_reg;
  assign RSP_ERR     = err_reg;

  always_comb begin
    load_ext = rbytes;
    case (dec.nbytes)
      3'd1:    load_ext = {{24{rbytes[7] & ~dec.zext}}, rbytes[7:0]};
      3'd2:    load_ext = {{16{rbytes[15] & ~dec.zext}}, rbytes[15:0]};
      default: load_ext = rbytes;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && REQ_VALID) begin
        we_reg     <= REQ_WE;
        funct3_reg <= REQ_FUNCT3;
        addr_reg   <= REQ_ADDR;
        wdata_reg  <= REQ_WDATA;
      end
      if (state_reg == ST_ACCESS) begin
        rdata_reg <= '0;
        err_reg   <= dec.illegal;
      end
      if (state_reg == ST_WAIT) begin
        rdata_reg <= load_ext;
      end
    end
  end

  // Lane enables come straight from the state register so a write in ACCESS
  // is already presented to the brams at the edge that leaves ACCESS.
  always_comb begin
    state_next = state_reg;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    LANE_WE    = '0;
    LANE_RE    = '0;
    case (state_reg)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (dec.illegal) begin
          state_next = ST_RESP;
        end else if (we_reg) begin
          LANE_WE    = mask;
          state_next = ST_RESP;
        end else begin
          LANE_RE    = mask;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: state_next = ST_RESP;
      ST_RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
